// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the team's magnitude comparators.
//
// Contents:
//   CMP_EQ / CMP_GT / CMP_LT : 2-bit result codes (A=B, A>B, A<B).
//                              The code 2'b11 is never produced.
//   cmp_state_t              : control states of the bit-serial comparators.
// -----------------------------------------------------------------------------
package cmp_pkg;

   // Result encoding shared with the parallel comparators
   localparam logic [1:0] CMP_EQ = 2'b00;
   localparam logic [1:0] CMP_GT = 2'b01;
   localparam logic [1:0] CMP_LT = 2'b10;

   // COLLECT gathers bit pairs, HOLD presents a finished result downstream
   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } cmp_state_t;

endpackage : cmp_pkg

// File: rtl/cmp_bit_update.sv
// -----------------------------------------------------------------------------
// cmp_bit_update
// Combinational update of a running comparison result by one bit pair.
// A bit position where the operands differ replaces whatever the running
// result was; equal bits leave it untouched. Fed LSB first this makes the
// most significant difference win; fed MSB first a caller would instead
// only apply the update while acc_in is still CMP_EQ.
//
// Ports:
//   a       in  1  current bit of operand A
//   b       in  1  current bit of operand B
//   acc_in  in  2  running result before this bit pair
//   acc_out out 2  running result after this bit pair
// -----------------------------------------------------------------------------
module cmp_bit_update
   import cmp_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic [1:0] acc_in,
   output logic [1:0] acc_out
);

   // A differing pair decides the relation for all bits seen so far
   always_comb begin
      acc_out = acc_in;
      if (a != b) begin
         acc_out = a ? CMP_GT : CMP_LT;
      end
   end

endmodule : cmp_bit_update

// File: rtl/serial_comparator_lsb.sv
// -----------------------------------------------------------------------------
// serial_comparator_lsb
// Bit-serial unsigned magnitude comparator, operands arrive LSB first, one
// bit pair per valid/ready transfer. After WIDTH bit pairs the relation of
// A to B is presented on out_res until the consumer takes it.
//
// Parameters:
//   WIDTH      bits per operand word (2..32)
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   clr        in   1  synchronous abort, discards any partial word
//   in_valid   in   1  in_a/in_b carry a valid bit pair
//   in_ready   out  1  block accepts a bit pair (COLLECT state)
//   in_a       in   1  operand A bit, LSB first
//   in_b       in   1  operand B bit, LSB first
//   out_valid  out  1  out_res holds a completed comparison (HOLD state)
//   out_ready  in   1  consumer accepts the result
//   out_res    out  2  CMP_GT / CMP_EQ / CMP_LT
// -----------------------------------------------------------------------------
module serial_comparator_lsb
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_a,
   input  logic       in_b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_res
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   cmp_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    acc_q, acc_d;
   logic [1:0]    res_q, res_d;
   logic [1:0]    acc_next;

   // Running result as it would be after accepting the current bit pair
   cmp_bit_update u_bit_update (
      .a       (in_a),
      .b       (in_b),
      .acc_in  (acc_q),
      .acc_out (acc_next)
   );

   // Handshake outputs decode straight from the state flop, so neither
   // depends combinationally on any input
   assign in_ready  = (state_q == COLLECT);
   assign out_valid = (state_q == HOLD);
   assign out_res   = res_q;

   // Next-state logic. clr wins over both transfers, so a bit offered in
   // the same cycle as clr is dropped. On the last bit the updated running
   // result goes straight into res so the word's final bit is included.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      res_d   = res_q;
      if (clr) begin
         state_d = COLLECT;
         cnt_d   = '0;
         acc_d   = CMP_EQ;
         res_d   = CMP_EQ;
      end else begin
         case (state_q)
            COLLECT: begin
               if (in_valid) begin
                  if (cnt_q == LAST_BIT) begin
                     res_d   = acc_next;
                     cnt_d   = '0;
                     acc_d   = CMP_EQ;
                     state_d = HOLD;
                  end else begin
                     acc_d = acc_next;
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = COLLECT;
               end
            end
            default: begin
               state_d = COLLECT;
            end
         endcase
      end
   end

   // State registers; reset clears any partial word and any old result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         acc_q   <= CMP_EQ;
         res_q   <= CMP_EQ;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
      end
   end

endmodule : serial_comparator_lsb

// File: tb/tb_serial_comparator_lsb.sv
// -----------------------------------------------------------------------------
// tb_serial_comparator_lsb
// Self-checking bench for serial_comparator_lsb with WIDTH=4. Inputs are
// driven and outputs sampled on the falling clock edge; transfers happen on
// the rising edge in between. Expected results come from plain integer
// comparison of the operand words.
// -----------------------------------------------------------------------------
module tb_serial_comparator_lsb;

   localparam int W = 4;
   localparam logic [1:0] GT = 2'b01;
   localparam logic [1:0] EQ = 2'b00;
   localparam logic [1:0] LT = 2'b10;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       in_valid;
   logic       in_ready;
   logic       in_a;
   logic       in_b;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_res;

   int nChecks = 0;
   int nFails  = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           gap;
      int           hold;
      logic [1:0]   exp;
   } vec_t;

   vec_t vecs[10];

   serial_comparator_lsb #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference relation of two unsigned words
   function automatic logic [1:0] refCompare(input int a, input int b);
      if (a > b) return GT;
      if (a < b) return LT;
      return EQ;
   endfunction

   // One comparison: counts it and reports a mismatch
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Sends one word LSB first with 'gap' idle cycles between bit pairs.
   // Returns at the falling edge after the last bit's transfer.
   task automatic sendWord(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int gap, input string tag);
      for (int i = 0; i < W; i++) begin
         int guard;
         in_a     = a[i];
         in_b     = b[i];
         in_valid = 1'b1;
         guard    = 0;
         while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (!in_ready) checkOutput({tag, " in_ready timeout"}, 0, 1);
         @(negedge clk);
         in_valid = 1'b0;
         if (i < W - 1) begin
            for (int g = 0; g < gap; g++) begin
               checkOutput({tag, " no early valid"}, out_valid, 0);
               @(negedge clk);
            end
         end
      end
   endtask

   // Full word: send, check latency/result, hold for 'hold' cycles with
   // out_ready low, then take the result and check the block frees up
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input int gap, input int hold,
                                input logic [1:0] exp, input string tag);
      out_ready = (hold == 0);
      sendWord(a, b, gap, tag);
      checkOutput({tag, " out_valid"}, out_valid, 1);
      checkOutput({tag, " out_res"}, out_res, exp);
      checkOutput({tag, " in_ready low"}, in_ready, 0);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         checkOutput({tag, " held valid"}, out_valid, 1);
         checkOutput({tag, " held res"}, out_res, exp);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput({tag, " released"}, out_valid, 0);
      checkOutput({tag, " ready again"}, in_ready, 1);
   endtask

   initial begin
      rst_n     = 1'b0;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_a      = 1'b0;
      in_b      = 1'b0;
      out_ready = 1'b0;

      vecs[0] = '{a: 4'd15, b: 4'd15, gap: 0, hold: 0, exp: EQ};
      vecs[1] = '{a: 4'd0,  b: 4'd0,  gap: 1, hold: 0, exp: EQ};
      vecs[2] = '{a: 4'd0,  b: 4'd15, gap: 0, hold: 1, exp: LT};
      vecs[3] = '{a: 4'd15, b: 4'd0,  gap: 2, hold: 0, exp: GT};
      vecs[4] = '{a: 4'd7,  b: 4'd8,  gap: 0, hold: 0, exp: LT};
      vecs[5] = '{a: 4'd8,  b: 4'd7,  gap: 1, hold: 2, exp: GT};
      vecs[6] = '{a: 4'd1,  b: 4'd0,  gap: 0, hold: 0, exp: GT};
      vecs[7] = '{a: 4'd14, b: 4'd15, gap: 0, hold: 0, exp: LT};
      vecs[8] = '{a: 4'd10, b: 4'd5,  gap: 0, hold: 0, exp: GT};
      vecs[9] = '{a: 4'd6,  b: 4'd9,  gap: 3, hold: 0, exp: LT};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset in_ready", in_ready, 1);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset out_res", out_res, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // A=9, B=6: MSB difference overrides LSB-side LT bits
      applyStimulus(4'd9, 4'd6, 0, 0, GT, "9vs6");

      // A=5, B=5 with a 3-cycle gap between bits 1 and 2
      out_ready = 1'b1;
      for (int i = 0; i < W; i++) begin
         in_a = 1'(4'd5 >> i);
         in_b = 1'(4'd5 >> i);
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         if (i == 1) begin
            for (int g = 0; g < 3; g++) begin
               checkOutput("5vs5 gap no valid", out_valid, 0);
               @(negedge clk);
            end
         end
         if (i == 2) checkOutput("5vs5 three bits", out_valid, 0);
      end
      checkOutput("5vs5 out_valid", out_valid, 1);
      checkOutput("5vs5 out_res", out_res, EQ);
      @(negedge clk);

      // A=3, B=11 held for 5 cycles; bits offered during HOLD are ignored
      out_ready = 1'b0;
      sendWord(4'd3, 4'd11, 0, "3vs11");
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_a     = 1'b1;
         in_b     = 1'b0;
         checkOutput("3vs11 hold valid", out_valid, 1);
         checkOutput("3vs11 hold res", out_res, LT);
         checkOutput("3vs11 hold in_ready", in_ready, 0);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("3vs11 released", out_valid, 0);
      checkOutput("3vs11 ready again", in_ready, 1);
      applyStimulus(4'd2, 4'd1, 0, 0, GT, "after hold");

      // Back-to-back 12/4 then 0/15 with in_valid held high throughout
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < W; i++) begin
         in_a = 1'(4'd12 >> i);
         in_b = 1'(4'd4 >> i);
         @(negedge clk);
      end
      checkOutput("b2b first valid", out_valid, 1);
      checkOutput("b2b first res", out_res, GT);
      in_a = 1'b1;
      in_b = 1'b0;
      @(negedge clk);
      checkOutput("b2b gap ready", in_ready, 1);
      for (int i = 0; i < W; i++) begin
         in_a = 1'(4'd0 >> i);
         in_b = 1'(4'd15 >> i);
         @(negedge clk);
         if (i < W - 1) checkOutput("b2b second early", out_valid, 0);
      end
      in_valid = 1'b0;
      checkOutput("b2b second valid", out_valid, 1);
      checkOutput("b2b second res", out_res, LT);
      @(negedge clk);

      // Asynchronous reset after 2 bits, then a fresh 6/6 word
      for (int i = 0; i < 2; i++) begin
         in_a = 1'b1;
         in_b = 1'b0;
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async rst in_ready", in_ready, 1);
      checkOutput("async rst out_valid", out_valid, 0);
      checkOutput("async rst out_res", out_res, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(4'd6, 4'd6, 0, 0, EQ, "post reset 6vs6");

      // Asynchronous reset while a result is held
      out_ready = 1'b0;
      sendWord(4'd9, 4'd2, 0, "rst in hold");
      checkOutput("rst in hold valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst in hold drop", out_valid, 0);
      checkOutput("rst in hold res", out_res, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // clr after 3 bits of 8/0, together with a valid 4th bit
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_a = 1'(4'd8 >> i);
         in_b = 1'b0;
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_a = 1'b1;
      in_b = 1'b0;
      clr  = 1'b1;
      @(negedge clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      checkOutput("clr no valid", out_valid, 0);
      checkOutput("clr in_ready", in_ready, 1);
      checkOutput("clr out_res", out_res, 0);
      applyStimulus(4'd1, 4'd2, 0, 0, LT, "after clr 1vs2");

      // Table-driven vectors
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].a, vecs[v].b, vecs[v].gap, vecs[v].hold,
                       vecs[v].exp, $sformatf("vec%0d", v));
      end

      // Randomized words checked against integer comparison
      for (int r = 0; r < 30; r++) begin
         int ra;
         int rb;
         ra = int'($urandom_range(0, 15));
         rb = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 15));
         applyStimulus(W'(ra), W'(rb), int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 3)), refCompare(ra, rb),
                       $sformatf("rand%0d %0d vs %0d", r, ra, rb));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

endmodule : tb_serial_comparator_lsb

// File: doc/serial_comparator_lsb.md
# serial_comparator_lsb

Bit-serial magnitude comparator that accepts two unsigned operands one bit pair per transfer, least-significant bit first, and reports the relation of A to B once a full word has arrived. It scans in the opposite order to the parallel MSB-priority comparator: the most recent differing bit overrides earlier ones. It sits behind serial links or shift-register front ends where parallel operands are not available. It uses the same 2-bit result encoding as the team's parallel comparators.

## Interface
Parameters:
- `WIDTH`, default 4: bits per operand word; legal range 2..32.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous abort; discards any partial word.
- `in_valid`  in  1  the bit pair on `in_a`/`in_b` is valid.
- `in_ready`  out  1  the block can accept a bit pair.
- `in_a`  in  1  current bit of operand A (LSB first).
- `in_b`  in  1  current bit of operand B (LSB first).
- `out_valid`  out  1  `out_res` holds a completed comparison.
- `out_ready`  in  1  the downstream consumer accepts the result.
- `out_res`  out  2  result: 01 means A>B, 00 means A=B, 10 means A<B; 11 is never driven.

## Operation
- A transfer on either port occurs when its valid and ready are both high at a rising edge.
- State machine with two states:
  - COLLECT: `in_ready`=1 and `out_valid`=0.
  - HOLD: `in_ready`=0 and `out_valid`=1.
- Bit counter `cnt`, width $clog2(WIDTH), plus a 2-bit running result `acc`.
- On each input transfer in COLLECT:
  - If `in_a`≠`in_b`, `acc` becomes 01 when `in_a`=1, else 10.
  - If the bits are equal, `acc` is unchanged.
  - `cnt` increments.
- On the transfer with `cnt`=WIDTH-1:
  - The updated `acc` is registered into `out_res`.
  - `cnt` goes to 0, `acc` goes to 00, and the state goes to HOLD.
- In HOLD, `out_res` is stable until the output transfer; then the state returns to COLLECT.
- `clr`=1 in any state: go to COLLECT with `cnt`=0, `acc`=00 and `out_res`=00.
  - `clr` has priority over any transfer in the same cycle; that input bit is dropped.
- Reset (`rst_n`=0) values: state COLLECT, `cnt`=0, `acc`=00, `out_res`=00, `out_valid`=0, `in_ready`=1.
  - Reset during a partial word discards it.
  - No stale result appears after reset.
- Input bits may arrive with arbitrary gaps. `in_valid`=0 cycles change nothing.
- Inputs presented while `in_ready`=0 are ignored, not queued.

## Timing
- `in_ready`, `out_valid` and `out_res` are registered outputs, with no combinational path from inputs.
- Latency: `out_valid` rises the cycle after the last bit's transfer edge.
- Minimum period per word: WIDTH input cycles plus 1 output cycle.
  - `in_ready` is low during the output-transfer cycle.
  - `in_ready` returns high the cycle after the output transfer.
- Backpressure: `out_valid` and `out_res` are held indefinitely while `out_ready`=0.
- `out_ready` may be high before `out_valid`. The transfer then completes in the first cycle `out_valid`=1.

## Structure
- Shared package `cmp_pkg` holds:
  - Result constants `CMP_EQ`=2'b00, `CMP_GT`=2'b01, `CMP_LT`=2'b10.
  - The `cmp_state_t` enum {COLLECT, HOLD}.
- One sub-module is natural: `cmp_bit_update`, which is combinational.
  - Inputs are (a, b, acc_in); output is acc_out.
  - It implements the "new difference overrides" rule.
  - It can be reused by an MSB-first variant with inverted priority.

## Test plan
- A=9 (1001), B=6 (0110), WIDTH=4, fed LSB first with no gaps, `out_ready`=1 → `out_valid` high one cycle after the 4th bit with `out_res`=01. The MSB difference overrides the LSB-side LT bits.
- A=5, B=5, with `in_valid` low for 3 cycles between bits 1 and 2 → `out_res`=00, and `cnt` does not advance during the gaps.
- A=3, B=11, with `out_ready` held low for 5 cycles → `out_res`=10 stays stable and `in_ready` stays 0 throughout. On the transfer, the next word is accepted starting the following cycle.
- Two back-to-back words with `in_valid` held high: A=12/B=4 and A=0/B=15 → `out_res` values 01 then 10. The bit presented during HOLD is ignored.
- Assert `rst_n` low asynchronously after 2 bits, then send A=6/B=6 → all outputs are at reset values immediately, and the next result is 00 computed from fresh bits only.
- Assert `clr` after 3 bits of A=8/B=0, in the same cycle as a valid input → no `out_valid`. A subsequent full word A=1/B=2 gives 10.
